// File: rtl/simple_ctrl_pkg.sv
// rtl/simple_ctrl_pkg.sv - shared constants and types for the simple CPU control unit
// Purpose: opcode and ALU select encodings, FSM state type, instruction-length helper.
// Ports: none (package).
package simple_ctrl_pkg;

   localparam int NUM_REGS = 4;

   localparam logic [3:0] OP_NOP  = 4'h0;
   localparam logic [3:0] OP_ADD  = 4'h1;
   localparam logic [3:0] OP_SUB  = 4'h2;
   localparam logic [3:0] OP_AND  = 4'h3;
   localparam logic [3:0] OP_NOT  = 4'h4;
   localparam logic [3:0] OP_MOV  = 4'h5;
   localparam logic [3:0] OP_LDI  = 4'h6;
   localparam logic [3:0] OP_JMP  = 4'h7;
   localparam logic [3:0] OP_JZ   = 4'h8;
   localparam logic [3:0] OP_JC   = 4'h9;
   localparam logic [3:0] OP_HALT = 4'hF;

   localparam logic [3:0] ALU_ADD   = 4'b1001;
   localparam logic [3:0] ALU_SUB   = 4'b0110;
   localparam logic [3:0] ALU_AND   = 4'b1011;
   localparam logic [3:0] ALU_NOT   = 4'b0101;
   localparam logic [3:0] ALU_MOV_A = 4'b1100;

   typedef enum logic [1:0] {
      ST_FETCH = 2'd0,
      ST_IMM   = 2'd1,
      ST_EXEC  = 2'd2,
      ST_HALT  = 2'd3
   } state_t;

   // Opcodes 6..9 carry an immediate byte after the instruction byte.
   function automatic logic is_two_byte(input logic [3:0] op);
      return (op == OP_LDI) || (op == OP_JMP) || (op == OP_JZ) || (op == OP_JC);
   endfunction

endpackage

// File: rtl/simple_regfile.sv
// rtl/simple_regfile.sv - 4x8 register file with two read ports and a debug port
// Purpose: operand storage for the control unit.
// Ports: clk, rst (sync, active-high); ra_sel/ra_data, rb_sel/rb_data (combinational reads);
//        dbg_sel/dbg_data (combinational debug read); we/wa/wd (synchronous write).
module simple_regfile
   import simple_ctrl_pkg::*;
#(
   parameter int NREGS = NUM_REGS
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] ra_sel,
   output logic [7:0] ra_data,
   input  logic [1:0] rb_sel,
   output logic [7:0] rb_data,
   input  logic [1:0] dbg_sel,
   output logic [7:0] dbg_data,
   input  logic       we,
   input  logic [1:0] wa,
   input  logic [7:0] wd
);

   logic [7:0] regs_q [NREGS];
   logic [7:0] regs_d [NREGS];

   always_comb begin
      regs_d = regs_q;
      if (we) regs_d[wa] = wd;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) regs_q[i] <= 8'h00;
      end else begin
         regs_q <= regs_d;
      end
   end

   assign ra_data  = regs_q[ra_sel];
   assign rb_data  = regs_q[rb_sel];
   assign dbg_data = regs_q[dbg_sel];

endmodule

// File: rtl/simple_ctrl.sv
// rtl/simple_ctrl.sv - multi-cycle sequencer driving the simple CPU ALU
// Purpose: fetches 1/2-byte instructions over req/ack, drives the ALU, writes back, latches flags.
// Ports: clk, rst (sync, active-high); imem_req/imem_addr/imem_ack/imem_data (instruction fetch);
//        alu_m/alu_s/alu_a/alu_b out, alu_t/alu_cf/alu_zf in (ALU);
//        pc, cf, zf, halted (status); dbg_sel/dbg_data (register debug read).
// Option: SIMPLE_CTRL_STEP_EN adds input step; each fetch then waits for an armed step pulse.
module simple_ctrl
   import simple_ctrl_pkg::*;
#(
   parameter int         NREGS    = NUM_REGS,
   parameter logic [7:0] RESET_PC = 8'h00
) (
   input  logic       clk,
   input  logic       rst,
`ifdef SIMPLE_CTRL_STEP_EN
   input  logic       step,
`endif
   output logic       imem_req,
   output logic [7:0] imem_addr,
   input  logic       imem_ack,
   input  logic [7:0] imem_data,
   output logic       alu_m,
   output logic [3:0] alu_s,
   output logic [7:0] alu_a,
   output logic [7:0] alu_b,
   input  logic [7:0] alu_t,
   input  logic       alu_cf,
   input  logic       alu_zf,
   output logic [7:0] pc,
   output logic       cf,
   output logic       zf,
   output logic       halted,
   input  logic [1:0] dbg_sel,
   output logic [7:0] dbg_data
);

   state_t     state_q, state_d;
   logic [7:0] pc_q, pc_d;
   logic [7:0] ir_q, ir_d;
   logic [7:0] imm_q, imm_d;
   logic       cf_q, cf_d;
   logic       zf_q, zf_d;
   logic       req_q, req_d;
   logic       halted_q, halted_d;
   logic       fetch_go;

   logic [7:0] rf_ra, rf_rb, rf_wd;
   logic       rf_we;

   logic [3:0] op;
   logic [1:0] rd, rs;

   assign op = ir_q[7:4];
   assign rd = ir_q[3:2];
   assign rs = ir_q[1:0];

`ifdef SIMPLE_CTRL_STEP_EN
   logic armed_q, armed_d;
   // A pulse in any state arms the next fetch; EXEC consumes the arm unless a pulse lands in it.
   assign fetch_go = armed_q | step;
   assign armed_d  = step | (armed_q & (state_q != ST_EXEC));
`else
   assign fetch_go = 1'b1;
`endif

   simple_regfile #(.NREGS(NREGS)) u_regfile (
      .clk      (clk),
      .rst      (rst),
      .ra_sel   (rs),
      .ra_data  (rf_ra),
      .rb_sel   (rd),
      .rb_data  (rf_rb),
      .dbg_sel  (dbg_sel),
      .dbg_data (dbg_data),
      .we       (rf_we),
      .wa       (rd),
      .wd       (rf_wd)
   );

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      ir_d     = ir_q;
      imm_d    = imm_q;
      cf_d     = cf_q;
      zf_d     = zf_q;
      req_d    = req_q;
      halted_d = halted_q;
      rf_we    = 1'b0;
      rf_wd    = alu_t;
      alu_m    = 1'b0;
      alu_s    = 4'b0000;
      alu_a    = 8'h00;
      alu_b    = 8'h00;

      case (state_q)
         // req_q low here is the mandatory idle gap between requests.
         ST_FETCH: begin
            if (!req_q) begin
               req_d = fetch_go;
            end else if (imem_ack) begin
               ir_d    = imem_data;
               pc_d    = pc_q + 8'd1;
               req_d   = 1'b0;
               state_d = is_two_byte(imem_data[7:4]) ? ST_IMM : ST_EXEC;
            end
         end
         ST_IMM: begin
            if (!req_q) begin
               req_d = 1'b1;
            end else if (imem_ack) begin
               imm_d   = imem_data;
               pc_d    = pc_q + 8'd1;
               req_d   = 1'b0;
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            alu_a   = rf_ra;
            alu_b   = rf_rb;
            state_d = ST_FETCH;
            case (op)
               OP_ADD: begin
                  alu_m = 1'b1;  alu_s = ALU_ADD;  rf_we = 1'b1;
                  cf_d  = alu_cf; zf_d = alu_zf;
               end
               OP_SUB: begin
                  alu_m = 1'b1;  alu_s = ALU_SUB;  rf_we = 1'b1;
                  cf_d  = alu_cf; zf_d = alu_zf;
               end
               OP_AND: begin alu_m = 1'b1; alu_s = ALU_AND;   rf_we = 1'b1; end
               OP_NOT: begin alu_m = 1'b1; alu_s = ALU_NOT;   rf_we = 1'b1; end
               OP_MOV: begin alu_m = 1'b0; alu_s = ALU_MOV_A; rf_we = 1'b1; end
               OP_LDI: begin rf_we = 1'b1; rf_wd = imm_q; end
               // Not-taken branches need nothing: pc already advanced past the immediate.
               OP_JMP: pc_d = imm_q;
               OP_JZ:  if (zf_q) pc_d = imm_q;
               OP_JC:  if (cf_q) pc_d = imm_q;
               OP_HALT: begin
                  state_d  = ST_HALT;
                  halted_d = 1'b1;
               end
               default: ;
            endcase
         end
         ST_HALT: ;
         default: state_d = ST_FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_FETCH;
         pc_q     <= RESET_PC;
         ir_q     <= 8'h00;
         imm_q    <= 8'h00;
         cf_q     <= 1'b0;
         zf_q     <= 1'b0;
         req_q    <= 1'b0;
         halted_q <= 1'b0;
`ifdef SIMPLE_CTRL_STEP_EN
         armed_q  <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         ir_q     <= ir_d;
         imm_q    <= imm_d;
         cf_q     <= cf_d;
         zf_q     <= zf_d;
         req_q    <= req_d;
         halted_q <= halted_d;
`ifdef SIMPLE_CTRL_STEP_EN
         armed_q  <= armed_d;
`endif
      end
   end

   assign imem_req  = req_q;
   assign imem_addr = pc_q;
   assign pc        = pc_q;
   assign cf        = cf_q;
   assign zf        = zf_q;
   assign halted    = halted_q;

endmodule
